// File: rtl/jtkiwi_pkg.sv
// -----------------------------------------------------------------------------
// jtkiwi_pkg
// Shared definitions for the SETA tilemap tile-row draw engine.
//   - state_t     : draw engine FSM encoding
//   - ROM_AW      : ROM word address width (byte address bits [19:2])
//   - PXW         : pixel width in bits (one nibble per pixel)
//   - PEN_TRANSP  : pen value treated as transparent (never written)
// -----------------------------------------------------------------------------
package jtkiwi_pkg;

    localparam int ROM_AW = 18;
    localparam int PXW    = 4;

    localparam logic [PXW-1:0] PEN_TRANSP = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DRAW = 2'd3
    } state_t;

endpackage

// File: rtl/jtkiwi_tile_draw_if.sv
// -----------------------------------------------------------------------------
// jtkiwi_tile_draw_if
// Bundles the three buses around the tile-row draw engine:
//   command : draw/busy handshake plus code, attr, xpos, ysub, flip
//   ROM     : rom_addr/rom_cs request, rom_ok/rom_data response
//   buffer  : buf_addr/buf_we/buf_din line buffer write port
// Modports:
//   master : the environment (tile scanner, ROM slot, line buffer)
//   slave  : the draw engine
// -----------------------------------------------------------------------------
interface jtkiwi_tile_draw_if #(
    parameter int PALW = 5
);
    // command
    logic          draw;
    logic          busy;
    logic [15:0]   code;
    logic [15:0]   attr;
    logic [8:0]    xpos;
    logic [3:0]    ysub;
    logic          flip;
    // ROM request slot
    logic [17:0]   rom_addr;
    logic          rom_cs;
    logic          rom_ok;
    logic [31:0]   rom_data;
    // line buffer write port
    logic [8:0]      buf_addr;
    logic            buf_we;
    logic [PALW+3:0] buf_din;

    modport master (
        output draw, code, attr, xpos, ysub, flip, rom_ok, rom_data,
        input  busy, rom_addr, rom_cs, buf_addr, buf_we, buf_din
    );

    modport slave (
        input  draw, code, attr, xpos, ysub, flip, rom_ok, rom_data,
        output busy, rom_addr, rom_cs, buf_addr, buf_we, buf_din
    );

endinterface

// File: rtl/jtkiwi_tile_draw.sv
// -----------------------------------------------------------------------------
// jtkiwi_tile_draw
// Tile-row draw engine. Accepts one draw command while idle, fetches the two
// 32-bit ROM words holding the 16-pixel tile row, and writes every
// non-transparent pixel into the line buffer, one pixel per cycle.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset; aborts any command in flight
//   bus    : command / ROM / line buffer buses (slave side)
//            busy, rom_addr, rom_cs, buf_addr, buf_we, buf_din are outputs
// Parameters:
//   PALW   : palette bits placed above the 4-bit pixel in buf_din
// -----------------------------------------------------------------------------
module jtkiwi_tile_draw
    import jtkiwi_pkg::*;
#(
    parameter int PALW = 5
)(
    input  logic              clk,
    input  logic              rst_n,
    jtkiwi_tile_draw_if.slave bus
);

    state_t            r_state;
    state_t            w_nxt;

    logic [12:0]       r_code;
    logic [PALW-1:0]   r_pal;
    logic [8:0]        r_xpos;
    logic [3:0]        r_ysub;
    logic              r_flip;
    logic              r_hf;        // effective horizontal flip
    logic              r_vf;        // effective vertical flip
    logic              r_half;      // which 8-pixel half is being drawn
    logic [2:0]        r_k;         // pixel within current half
    logic [31:0]       r_sr;        // pixel shift register

    logic [PXW-1:0]    w_nib;
    logic [8:0]        w_x;
    logic              w_drawing;
    logic              w_busy;
    logic              w_cs;
    logic              w_we;
    logic [8:0]        w_baddr;
    logic [PALW+3:0]   w_bdin;
    logic              w_unused;

    // Code bits above 12 and attr bits outside flips/palette are not used.
    assign w_unused = &{1'b0, bus.code[15:13], bus.attr};

    // ---------------------------------------------------------------------
    // State register and datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_pal   <= '0;
            r_xpos  <= '0;
            r_ysub  <= '0;
            r_flip  <= 1'b0;
            r_hf    <= 1'b0;
            r_vf    <= 1'b0;
            r_half  <= 1'b0;
            r_k     <= '0;
            r_sr    <= '0;
        end else begin
            r_state <= w_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.draw) begin
                        r_code <= bus.code[12:0];
                        r_pal  <= bus.attr[PALW-1:0];
                        r_xpos <= bus.xpos;
                        r_ysub <= bus.ysub;
                        r_flip <= bus.flip;
                        // global flip inverts both tile flips
                        r_hf   <= bus.attr[15] ^ bus.flip;
                        r_vf   <= bus.attr[14] ^ bus.flip;
                        r_half <= 1'b0;
                        r_k    <= '0;
                    end
                end
                ST_WAIT: begin
                    if (bus.rom_ok) begin
                        r_sr <= bus.rom_data;
                        r_k  <= '0;
                    end
                end
                ST_DRAW: begin
                    // hflip walks the word from the top nibble down
                    r_sr <= r_hf ? {r_sr[27:0], 4'd0} : {4'd0, r_sr[31:4]};
                    r_k  <= r_k + 3'd1;
                    if (r_k == 3'd7)
                        r_half <= ~r_half;
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Next state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_nxt     = r_state;
        w_busy    = 1'b1;
        w_cs      = 1'b0;
        w_drawing = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.draw)
                    w_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                // rom_ok here may still belong to the previous request
                w_cs  = 1'b1;
                w_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_cs = 1'b1;
                if (bus.rom_ok)
                    w_nxt = ST_DRAW;
            end
            ST_DRAW: begin
                w_drawing = 1'b1;
                if (r_k == 3'd7)
                    w_nxt = r_half ? ST_IDLE : ST_ADDR;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    assign w_nib = r_hf ? r_sr[31:28] : r_sr[3:0];
    // draw index i = half*8 + k, 9-bit wrap on screen x
    assign w_x   = r_xpos + {5'd0, r_half, r_k};

    always_comb begin
        w_we    = 1'b0;
        w_baddr = '0;
        w_bdin  = '0;
        if (w_drawing) begin
            w_we    = (w_nib != PEN_TRANSP);
            w_baddr = r_flip ? ~w_x : w_x;
            w_bdin  = {r_pal, w_nib};
        end
    end

    assign bus.busy     = w_busy;
    assign bus.rom_cs   = w_cs;
    assign bus.rom_addr = {r_code, r_ysub ^ {4{r_vf}}, r_half ^ r_hf};
    assign bus.buf_we   = w_we;
    assign bus.buf_addr = w_baddr;
    assign bus.buf_din  = w_bdin;

endmodule
